cpu_step_controller: RTL

//   Sequencer for the single-cycle test core: owns the PC, fetches each instruction

---
 rtl/cpu_step_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_controller.sv
// Step sequencer for the single-cycle test core: owns the PC, fetches over a req/valid
// handshake, gates one register commit per step and latches the ALU result onto LEDs.
module cpu_step_controller #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     LED_WIDTH       = 6,
    parameter logic [XLEN-1:0] RESET_PC        = {XLEN{1'b0}},
    parameter int unsigned     DEBOUNCE_CYCLES = 270000,
    parameter int unsigned     RUN_DIV         = 2700000,
    parameter logic [XLEN-1:0] HALT_INSN       = 32'h0010_0073
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 btn,
    input  logic                 mode_run,
    output logic                 fetch_req,
    output logic [XLEN-1:0]      fetch_addr,
    input  logic                 fetch_valid,
    input  logic [XLEN-1:0]      fetch_data,
    output logic [XLEN-1:0]      instruction,
    input  logic [XLEN-1:0]      result,
    output logic                 commit,
    output logic [XLEN-1:0]      pc,
    output logic [LED_WIDTH-1:0] led,
    output logic                 halted
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(3'd4);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_COMMIT = 3'd4
    } state_e;

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             press_s, tick_s, step_go_s;

    state_e                state_q, state_d;
    logic [XLEN-1:0]       pc_q, pc_d;
    logic [XLEN-1:0]       instr_q, instr_d;
    logic [LED_WIDTH-1:0]  led_q, led_d;
    logic                  halted_q, halted_d;
    logic                  fetch_req_q, fetch_req_d;
    logic                  commit_q, commit_d;

    // Button debounce: stable only follows the synchronised input after a full quiet window
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        press_s   = 1'b0;
        if (sync2_q != stable_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                stable_d  = sync2_q;
                deb_cnt_d = {DEB_W{1'b0}};
                press_s   = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1'b1);
            end
        end else begin
            deb_cnt_d = {DEB_W{1'b0}};
        end
    end

    // Free-run divider: idles at zero in single-step mode so run mode always starts fresh
    always_comb begin
        div_d  = div_q;
        tick_s = 1'b0;
        if (mode_run) begin
            if (div_q == DIV_LAST) begin
                div_d  = {DIV_W{1'b0}};
                tick_s = 1'b1;
            end else begin
                div_d = div_q + DIV_W'(1'b1);
            end
        end else begin
            div_d = {DIV_W{1'b0}};
        end
    end

    assign step_go_s = mode_run ? tick_s : press_s;

    // Step FSM next-state; step requests outside IDLE are dropped, not queued
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        led_d    = led_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: begin
                if (step_go_s && !halted_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetch_valid) begin
                    instr_d = fetch_data;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_EXEC: begin
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (instr_q == HALT_INSN) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d  = pc_q + PC_STEP;
                    led_d = ~result[LED_WIDTH-1:0];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered so they line up exactly with the FETCH/COMMIT state cycles
    always_comb begin
        fetch_req_d = (state_d == ST_FETCH);
        commit_d    = (state_d == ST_COMMIT) && (instr_d != HALT_INSN);
    end

    // Input synchroniser, debounce and divider state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            deb_cnt_q <= {DEB_W{1'b0}};
            div_q     <= {DIV_W{1'b0}};
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            deb_cnt_q <= deb_cnt_d;
            div_q     <= div_d;
        end
    end

    // Sequencer state and architectural outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            instr_q     <= {XLEN{1'b0}};
            led_q       <= {LED_WIDTH{1'b1}};
            halted_q    <= 1'b0;
            fetch_req_q <= 1'b0;
            commit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            led_q       <= led_d;
            halted_q    <= halted_d;
            fetch_req_q <= fetch_req_d;
            commit_q    <= commit_d;
        end
    end

    assign fetch_req   = fetch_req_q;
    assign fetch_addr  = pc_q;
    assign instruction = instr_q;
    assign commit      = commit_q;
    assign pc          = pc_q;
    assign led         = led_q;
    assign halted      = halted_q;

    generate
        if (LED_WIDTH < XLEN) begin : g_result_upper
            logic unused_result_s;
            assign unused_result_s = ^result[XLEN-1:LED_WIDTH];
        end
    endgenerate

endmodule
